uctl_bank_router: RTL

- Parametrised successor to the combinational bank select in the USB controller register/buffer path.
- Decodes the bank index from the offset address and drives one-hot registered bank requests, holding each until the bank acknowledges.
- Tracks outstanding reads in order and returns the selected bank's read data with a registered data-valid.
- Sits between the controller's local-bus requester and NUM_BANKS memory/register banks.

---
 rtl/uctl_bank_router.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uctl_bank_router.sv
// rtl/uctl_bank_router.sv - one-hot bank request router with in-order read return
//
// Purpose:
//   Decodes the bank index carried on uctl_offsetAddr into a registered one-hot
//   bank request that is held until the selected bank acknowledges. Accepted
//   reads are remembered in a small in-order queue so that read data can be
//   taken only from the bank at the head of the queue; data-valids from any
//   other bank are dropped and flagged in a sticky sequence-error bit.
//
// Ports:
//   uctl_clk           in   system clock, rising edge
//   uctl_rst_n         in   asynchronous active-low reset
//   uctl_req           in   access request, held until uctl_rdAck
//   uctl_wr            in   1 = write, 0 = read, sampled with uctl_req
//   uctl_offsetAddr    in   bank index
//   uctl_busy          out  router cannot accept a new request
//   uctl_bankReq       out  registered one-hot bank request
//   uctl_bankWr        out  registered write qualifier for uctl_bankReq
//   uctl_bankAck       in   per-bank accept
//   uctl_bankDVl       in   per-bank read-data valid
//   uctl_bankRdData    in   concatenated bank read data, bank 0 in the LSBs
//   uctl_rdAck         out  access accepted by the target bank
//   uctl_dValid        out  registered read-data valid (one-cycle pulse)
//   uctl_rdData        out  registered read data, held between pulses
//   uctl_outstCnt      out  number of outstanding reads
//   uctl_seqErr        out  sticky out-of-order / unexpected data-valid flag
//   uctl_timeoutErr    out  one-cycle ack-timeout pulse (UCTL_BANK_TIMEOUT_EN only)
//
// Configuration:
//   UCTL_BANK_TIMEOUT_EN  when defined, a request that is not acknowledged
//                         within TIMEOUT_CYC cycles is abandoned.

module uctl_bank_router #(
   parameter int NUM_BANKS   = 4,
   parameter int BANK_SEL_W  = 2,
   parameter int DATA_W      = 32,
   parameter int OUTST_DEPTH = 4,
   parameter int OUTST_PTR_W = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                        uctl_clk,
   input  logic                        uctl_rst_n,
   input  logic                        uctl_req,
   input  logic                        uctl_wr,
   input  logic [BANK_SEL_W-1:0]       uctl_offsetAddr,
   output logic                        uctl_busy,
   output logic [NUM_BANKS-1:0]        uctl_bankReq,
   output logic                        uctl_bankWr,
   input  logic [NUM_BANKS-1:0]        uctl_bankAck,
   input  logic [NUM_BANKS-1:0]        uctl_bankDVl,
   input  logic [NUM_BANKS*DATA_W-1:0] uctl_bankRdData,
   output logic                        uctl_rdAck,
   output logic                        uctl_dValid,
   output logic [DATA_W-1:0]           uctl_rdData,
   output logic [OUTST_PTR_W:0]        uctl_outstCnt,
`ifdef UCTL_BANK_TIMEOUT_EN
   output logic                        uctl_timeoutErr,
`endif
   output logic                        uctl_seqErr
);

   // Elaboration-time guards on the parameter relationships the logic relies on.
   if (NUM_BANKS < 2 || NUM_BANKS != (1 << BANK_SEL_W)) begin : g_bad_num_banks
      $error("NUM_BANKS must be a power of 2, at least 2, and equal 2**BANK_SEL_W");
   end
   if (OUTST_DEPTH != (1 << OUTST_PTR_W)) begin : g_bad_outst_depth
      $error("OUTST_DEPTH must equal 2**OUTST_PTR_W");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

   localparam logic [OUTST_PTR_W:0] FULL_CNT = (OUTST_PTR_W+1)'(OUTST_DEPTH);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_t;

   state_t                  r_state;
   logic [BANK_SEL_W-1:0]   r_sel_idx;
   logic                    r_wr_flag;
   logic [NUM_BANKS-1:0]    r_bank_req;
   logic                    r_bank_wr;

   logic [BANK_SEL_W-1:0]   r_fifo [OUTST_DEPTH];
   logic [OUTST_PTR_W-1:0]  r_wr_ptr;
   logic [OUTST_PTR_W-1:0]  r_rd_ptr;
   logic [OUTST_PTR_W:0]    r_count;

   logic                    r_dvalid;
   logic [DATA_W-1:0]       r_rd_data;
   logic                    r_seq_err;

   logic                    w_fifo_full;
   logic                    w_fifo_empty;
   logic                    w_accept;
   logic                    w_ack;
   logic                    w_req_end;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_stray;
   logic [BANK_SEL_W-1:0]   w_head;
   logic [NUM_BANKS-1:0]    w_head_mask;
   logic [DATA_W-1:0]       w_head_data;

   assign w_fifo_full  = (r_count == FULL_CNT);
   assign w_fifo_empty = (r_count == '0);

   // A write is blocked by a full read queue as well; this keeps the accept
   // condition independent of the access type.
   assign w_accept = (r_state == ST_IDLE) & uctl_req & ~w_fifo_full;
   assign w_ack    = (r_state == ST_REQ) & uctl_bankAck[r_sel_idx];
   assign w_push   = w_ack & ~r_wr_flag;

   // Only the bank at the head of the queue may return data; with an empty
   // queue the mask is zero so every data-valid counts as stray.
   assign w_head      = r_fifo[r_rd_ptr];
   assign w_head_mask = w_fifo_empty ? '0 : (NUM_BANKS'(1) << w_head);
   assign w_pop       = |(uctl_bankDVl & w_head_mask);
   assign w_stray     = |(uctl_bankDVl & ~w_head_mask);

   always_comb begin
      w_head_data = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (w_head == BANK_SEL_W'(b)) begin
            w_head_data = uctl_bankRdData[b*DATA_W +: DATA_W];
         end
      end
   end

`ifdef UCTL_BANK_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TO_W-1:0] r_to_cnt;
   logic            r_timeout_err;
   logic            w_timeout;

   // The counter holds the number of cycles already spent in REQ, so the last
   // permitted cycle is TIMEOUT_CYC-1 and the abort lands TIMEOUT_CYC cycles
   // after REQ entry.
   assign w_timeout = (r_state == ST_REQ) & ~uctl_bankAck[r_sel_idx] &
                      (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
   assign w_req_end = w_ack | w_timeout;

   always_ff @(posedge uctl_clk or negedge uctl_rst_n) begin
      if (!uctl_rst_n) begin
         r_to_cnt      <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= w_timeout;
         if (w_accept) begin
            r_to_cnt <= '0;
         end else if (r_state == ST_REQ && !w_req_end) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
         end
      end
   end

   assign uctl_timeoutErr = r_timeout_err;
`else
   assign w_req_end = w_ack;
`endif

   // Request FSM: IDLE samples the requester, REQ holds the one-hot request
   // until the selected bank accepts it (or, optionally, until timeout).
   always_ff @(posedge uctl_clk or negedge uctl_rst_n) begin
      if (!uctl_rst_n) begin
         r_state    <= ST_IDLE;
         r_sel_idx  <= '0;
         r_wr_flag  <= 1'b0;
         r_bank_req <= '0;
         r_bank_wr  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state    <= ST_REQ;
                  r_sel_idx  <= uctl_offsetAddr;
                  r_wr_flag  <= uctl_wr;
                  r_bank_req <= NUM_BANKS'(1) << uctl_offsetAddr;
                  r_bank_wr  <= uctl_wr;
               end
            end
            ST_REQ: begin
               if (w_req_end) begin
                  r_state    <= ST_IDLE;
                  r_bank_req <= '0;
                  r_bank_wr  <= 1'b0;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_bank_req <= '0;
               r_bank_wr  <= 1'b0;
            end
         endcase
      end
   end

   // Read-order queue. A push can only happen from REQ, which was entered
   // with the queue not full, so overflow is impossible by construction.
   always_ff @(posedge uctl_clk or negedge uctl_rst_n) begin
      if (!uctl_rst_n) begin
         for (int i = 0; i < OUTST_DEPTH; i++) begin
            r_fifo[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= r_sel_idx;
            r_wr_ptr         <= r_wr_ptr + OUTST_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + OUTST_PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (OUTST_PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (OUTST_PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Read return and sticky sequence error.
   always_ff @(posedge uctl_clk or negedge uctl_rst_n) begin
      if (!uctl_rst_n) begin
         r_dvalid  <= 1'b0;
         r_rd_data <= '0;
         r_seq_err <= 1'b0;
      end else begin
         r_dvalid <= w_pop;
         if (w_pop) begin
            r_rd_data <= w_head_data;
         end
         if (w_stray) begin
            r_seq_err <= 1'b1;
         end
      end
   end

   assign uctl_busy     = (r_state == ST_REQ) | w_fifo_full;
   assign uctl_bankReq  = r_bank_req;
   assign uctl_bankWr   = r_bank_wr;
   assign uctl_rdAck    = w_ack;
   assign uctl_dValid   = r_dvalid;
   assign uctl_rdData   = r_rd_data;
   assign uctl_outstCnt = r_count;
   assign uctl_seqErr   = r_seq_err;

endmodule
